dffnsre_8lut_capture_ser: RTL and testbench
===========================================

// Module: dffnsre_8lut_capture_ser
// PURPOSE
//  Downstream consumer of the 8-flop dffnsre/LUT-mux stage. Captures the Q_1..Q_8 word (packed as Q_in)
//  when sel qualifies it, buffers it in a small FIFO, and serialises each word LSB-first over a valid/ready
//  link. Lets the ArchBench harness drain flop contents through one pin without stalling the capture side.
// PARAMETERS
//  WIDTH  8  captured word width; Q_in[0]=Q_1 .. Q_in[7]=Q_8
//  DEPTH  4  FIFO entries; power of 2, >=2
//  OVF_W  8  width of saturating drop counter
// PORTS
//  C          in   1            clock; all state updates on rising edge (upstream flops update on falling edge)
//  R          in   1            reset, synchronous, active-low
//  cap_en     in   1            capture request this cycle
//  sel        in   1            upstream mux select; 0 = Q bus forced all-ones, never captured
//  Q_in       in   WIDTH        upstream Q word
//  ser_ready  in   1            sink accepts current bit
//  ser_valid  out  1            ser_data valid
//  ser_data   out  1            serial bit
//  ser_last   out  1            high with the final bit of a frame
//  fifo_full  out  1            count==DEPTH
//  fifo_empty out  1            count==0
//  ovf_cnt    out  OVF_W        words dropped because FIFO full; saturates at all-ones
// BEHAVIOUR
//  - Reset (R==0 at edge): FIFO count=0, pointers=0, state IDLE, ser_valid=0, ser_data=0, ser_last=0,
//    fifo_full=0, fifo_empty=1, ovf_cnt=0. Reset mid-frame aborts the frame; no ser_last emitted.
//  - push = cap_en & sel & ~fifo_full; writes Q_in. cap_en & sel & fifo_full -> word dropped, ovf_cnt+1
//    unless all-ones. cap_en & ~sel -> ignored, no drop counted.
//  - fifo_full gates push even when a pop happens the same cycle (full+pop+push = drop).
//  - Push and pop in the same cycle with count<DEPTH: count unchanged, both pointers advance, wrap mod DEPTH.
//  - FSM states IDLE, SHIFT (+PAR with macro):
//    IDLE : fifo_empty=0 -> pop head into shift reg, bit_idx=0, go SHIFT. Else stay; ser_valid=0.
//    SHIFT: ser_valid=1, ser_data=sh[bit_idx]. On ser_valid&ser_ready: bit_idx+1; when bit WIDTH-1
//           accepted -> PAR (macro) else IDLE. No valid&ready -> hold ser_data and bit_idx stable.
//    PAR  : ser_data = ^word (even parity); on accept -> IDLE.
//  - ser_last = 1 on last bit of frame (bit WIDTH-1, or parity bit with macro); 0 otherwise.
//  - Latency: word pushed at edge k -> popped at edge k+1 -> ser_valid=1 with bit 0 after edge k+1.
//  - Back-to-back: IDLE costs one bubble cycle between frames (ser_valid=0 for 1 cycle).
//  - ser_valid, once high, stays high until its bit is accepted (AXI-style, no retraction).
//  - Outputs are registered; no combinational path from ser_ready to ser_valid/ser_data.
// CONFIGURATION
//  DFFNSRE_CAP_PARITY_EN defined: frame = WIDTH data bits + 1 even-parity bit; ser_last on parity bit.
//  Not defined: frame = WIDTH data bits; ser_last on bit WIDTH-1; PAR state absent.
// TESTING
//  1 Reset: R=0 for 2 cycles with cap_en=1,sel=1 -> fifo_empty=1, ser_valid=0, ovf_cnt=0 throughout.
//  2 Single word: Q_in=8'hA5, cap_en/sel=1 one cycle, ser_ready=1 -> ser_data 1,0,1,0,0,1,0,1 on 8
//    consecutive cycles starting 1 cycle after capture; ser_last on 8th bit (9th = parity 0 with macro).
//  3 sel gating: cap_en=1, sel=0, Q_in=8'hFF for 10 cycles -> fifo_empty stays 1, ovf_cnt=0.
//  4 Overflow: ser_ready=0, capture 6 words 01..06, DEPTH=4 -> fifo_full=1, ovf_cnt=1 (word 01 popped into
//    shifter), then ser_ready=1 -> frames 01,02,03,04,05 in order; 06 lost; ovf_cnt holds 1.
//  5 Backpressure: toggle ser_ready randomly during word 8'h3C -> bit order intact, ser_data stable while
//    ser_valid&~ser_ready.
//  6 Saturation/abort: 300 drops -> ovf_cnt=8'hFF; assert R=0 mid-frame -> ser_valid=0 next edge, no ser_last.

Source files
------------

// File: rtl/dffnsre_8lut_capture_ser.sv
// Captures sel-qualified Q words into a small FIFO and serialises each word LSB-first over valid/ready.
// Define DFFNSRE_CAP_PARITY_EN to append an even-parity bit to every frame.
module dffnsre_8lut_capture_ser #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int OVF_W = 8
) (
  input  logic             C,
  input  logic             R,
  input  logic             cap_en,
  input  logic             sel,
  input  logic [WIDTH-1:0] Q_in,
  input  logic             ser_ready,
  output logic             ser_valid,
  output logic             ser_data,
  output logic             ser_last,
  output logic             fifo_full,
  output logic             fifo_empty,
  output logic [OVF_W-1:0] ovf_cnt
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

`ifdef DFFNSRE_CAP_PARITY_EN
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_PAR} state_t;
  localparam bit DATA_ENDS_FRAME = 1'b0;
`else
  typedef enum logic [0:0] {S_IDLE, S_SHIFT} state_t;
  localparam bit DATA_ENDS_FRAME = 1'b1;
`endif

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [OVF_W-1:0] r_ovf;
  logic [WIDTH-1:0] r_sh;
  logic [IW-1:0]    r_idx;
  state_t           r_state;
  logic             r_valid, r_data, r_last;

  logic w_full, w_empty, w_push, w_pop, w_drop, w_accept;

  assign w_full   = (r_count == DEPTH_C);
  assign w_empty  = (r_count == '0);
  // A full FIFO refuses the word even if the serialiser pops in the same cycle.
  assign w_push   = cap_en & sel & ~w_full;
  assign w_drop   = cap_en & sel & w_full;
  assign w_pop    = (r_state == S_IDLE) & ~w_empty;
  assign w_accept = r_valid & ser_ready;

  assign ser_valid  = r_valid;
  assign ser_data   = r_data;
  assign ser_last   = r_last;
  assign fifo_full  = w_full;
  assign fifo_empty = w_empty;
  assign ovf_cnt    = r_ovf;

  always_ff @(posedge C) begin
    if (w_push) r_mem[r_wr_ptr] <= Q_in;
  end

  always_ff @(posedge C) begin
    if (!R) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_drop && (r_ovf != '1)) r_ovf <= r_ovf + OVF_W'(1);
    end
  end

  always_ff @(posedge C) begin
    if (!R) begin
      r_state <= S_IDLE;
      r_sh    <= '0;
      r_idx   <= '0;
      r_valid <= 1'b0;
      r_data  <= 1'b0;
      r_last  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!w_empty) begin
            r_sh    <= r_mem[r_rd_ptr];
            r_idx   <= '0;
            r_valid <= 1'b1;
            r_data  <= r_mem[r_rd_ptr][0];
            r_last  <= DATA_ENDS_FRAME && (WIDTH == 1);
            r_state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (w_accept) begin
            if (r_idx == LAST_IDX) begin
`ifdef DFFNSRE_CAP_PARITY_EN
              r_data  <= ^r_sh;
              r_last  <= 1'b1;
              r_state <= S_PAR;
`else
              r_valid <= 1'b0;
              r_data  <= 1'b0;
              r_last  <= 1'b0;
              r_state <= S_IDLE;
`endif
            end else begin
              r_idx  <= r_idx + IW'(1);
              r_data <= r_sh[r_idx + IW'(1)];
              r_last <= DATA_ENDS_FRAME && ((r_idx + IW'(1)) == LAST_IDX);
            end
          end
        end
`ifdef DFFNSRE_CAP_PARITY_EN
        S_PAR: begin
          if (w_accept) begin
            r_valid <= 1'b0;
            r_data  <= 1'b0;
            r_last  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
`endif
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dffnsre_8lut_capture_ser.sv
// Randomised scoreboard bench for dffnsre_8lut_capture_ser; honours DFFNSRE_CAP_PARITY_EN.
`timescale 1ns/1ps
module tb_dffnsre_8lut_capture_ser;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int OVF_W = 8;
`ifdef DFFNSRE_CAP_PARITY_EN
  localparam bit PAR_ON = 1'b1;
  localparam int FRAME  = WIDTH + 1;
`else
  localparam bit PAR_ON = 1'b0;
  localparam int FRAME  = WIDTH;
`endif

  logic             clk = 1'b0;
  logic             R, cap_en, sel, ser_ready;
  logic [WIDTH-1:0] Q_in;
  logic             ser_valid, ser_data, ser_last, fifo_full, fifo_empty;
  logic [OVF_W-1:0] ovf_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dffnsre_8lut_capture_ser #(.WIDTH(WIDTH), .DEPTH(DEPTH), .OVF_W(OVF_W)) dut (
    .C(clk), .R(R), .cap_en(cap_en), .sel(sel), .Q_in(Q_in), .ser_ready(ser_ready),
    .ser_valid(ser_valid), .ser_data(ser_data), .ser_last(ser_last),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .ovf_cnt(ovf_cnt)
  );

  // Reference model: queue of buffered words, a busy flag with bits left in the frame, drop counter.
  logic [WIDTH-1:0] m_q[$];
  logic [1:0]       exp_q[$];   // {data, last} per expected serial bit
  logic             m_busy = 1'b0;
  int               m_left = 0;
  logic [OVF_W-1:0] m_ovf  = '0;
  logic             m_was_full;
  logic [WIDTH-1:0] m_word;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      if (!R) begin
        m_q.delete();
        exp_q.delete();
        m_busy = 1'b0;
        m_left = 0;
        m_ovf  = '0;
      end else begin
        m_was_full = (m_q.size() == DEPTH);
        if (m_busy) begin
          if (ser_ready) begin
            m_left--;
            if (m_left == 0) m_busy = 1'b0;
          end
        end else if (m_q.size() != 0) begin
          m_word = m_q.pop_front();
          for (int i = 0; i < WIDTH; i++)
            exp_q.push_back({m_word[i], (i == WIDTH - 1) && !PAR_ON});
          if (PAR_ON) exp_q.push_back({^m_word, 1'b1});
          m_busy = 1'b1;
          m_left = FRAME;
        end
        if (cap_en && sel) begin
          if (m_was_full) begin
            if (m_ovf != '1) m_ovf = m_ovf + 1'b1;
          end else begin
            m_q.push_back(Q_in);
          end
        end
      end
    end
  end

  // Monitor: compare status against the model each cycle and pop the scoreboard on every handshake.
  logic             held_valid = 1'b0;
  logic [1:0]       held;
  logic [1:0]       e;
  logic [WIDTH-1:0] asm_word;
  int               bitn = 0;
  int               frames = 0;

  initial begin
    forever begin
      @(negedge clk);
      check("ser_valid", 32'(ser_valid), 32'(m_busy));
      check("fifo_empty", 32'(fifo_empty), 32'(m_q.size() == 0));
      check("fifo_full", 32'(fifo_full), 32'(m_q.size() == DEPTH));
      check("ovf_cnt", 32'(ovf_cnt), 32'(m_ovf));
      if (!ser_valid) check("ser_last_idle", 32'(ser_last), 32'd0);
      if (held_valid && ser_valid) check("hold_stable", 32'({ser_data, ser_last}), 32'(held));
      held_valid = 1'b0;
      if (!R) begin
        bitn = 0;
      end else if (ser_valid) begin
        if (ser_ready) begin
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_empty: got bit %0d expected no bit at %0t", ser_data, $time);
          end else begin
            e = exp_q.pop_front();
            check("ser_data", 32'(ser_data), 32'(e[1]));
            check("ser_last", 32'(ser_last), 32'(e[0]));
            if (bitn < WIDTH) asm_word[bitn] = ser_data;
            bitn++;
            if (e[0]) begin
              frames++;
              $display("[TB] frame %0d received word=%02h bits=%0d", frames, asm_word, bitn);
              bitn = 0;
            end
          end
        end else begin
          held_valid = 1'b1;
          held = {ser_data, ser_last};
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic drain();
    int k;
    ser_ready = 1'b1;
    cap_en = 1'b0;
    k = 0;
    while ((m_q.size() != 0 || m_busy) && k < 300) begin
      tick(1);
      k++;
    end
    check("drain_done", 32'(k < 300), 32'd1);
    tick(2);
    check("exp_queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    R = 1'b0; cap_en = 1'b1; sel = 1'b1; Q_in = WIDTH'($urandom); ser_ready = 1'b0;
    tick(2);
    check("rst_empty", 32'(fifo_empty), 32'd1);
    check("rst_valid", 32'(ser_valid), 32'd0);
    check("rst_ovf", 32'(ovf_cnt), 32'd0);
    R = 1'b1; cap_en = 1'b0;
    tick(1);

    // Single word, first bit one cycle after capture.
    Q_in = 8'hA5; cap_en = 1'b1; sel = 1'b1; ser_ready = 1'b1;
    tick(1);
    cap_en = 1'b0;
    tick(1);
    check("a5_latency_valid", 32'(ser_valid), 32'd1);
    check("a5_bit0", 32'(ser_data), 32'd1);
    drain();

    // sel low: nothing captured, nothing counted.
    cap_en = 1'b1; sel = 1'b0; Q_in = 8'hFF;
    tick(10);
    check("sel0_empty", 32'(fifo_empty), 32'd1);
    check("sel0_ovf", 32'(ovf_cnt), 32'd0);
    cap_en = 1'b0; sel = 1'b1;
    tick(1);

    // Overflow: six words with the sink stalled.
    ser_ready = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      Q_in = WIDTH'(i); cap_en = 1'b1;
      tick(1);
    end
    cap_en = 1'b0;
    tick(1);
    check("ovf_full", 32'(fifo_full), 32'd1);
    check("ovf_count1", 32'(ovf_cnt), 32'd1);
    drain();
    check("ovf_hold", 32'(ovf_cnt), 32'd1);

    // Backpressure during word 3C.
    Q_in = 8'h3C; cap_en = 1'b1; ser_ready = 1'($urandom_range(0, 1));
    tick(1);
    cap_en = 1'b0;
    repeat (40) begin
      ser_ready = 1'($urandom_range(0, 1));
      tick(1);
    end
    drain();

    // Random traffic.
    repeat (400) begin
      cap_en    = 1'($urandom_range(0, 1));
      sel       = ($urandom_range(0, 3) != 0);
      Q_in      = WIDTH'($urandom);
      ser_ready = ($urandom_range(0, 2) != 0);
      tick(1);
    end
    drain();
    sel = 1'b1;

    // Saturate the drop counter, then abort a frame with reset.
    ser_ready = 1'b0; cap_en = 1'b1;
    repeat (310) begin
      Q_in = WIDTH'($urandom);
      tick(1);
    end
    cap_en = 1'b0;
    tick(1);
    check("sat_ovf", 32'(ovf_cnt), 32'hFF);
    ser_ready = 1'b1;
    tick(3);
    check("abort_midframe_valid", 32'(ser_valid), 32'd1);
    R = 1'b0;
    tick(1);
    check("abort_valid", 32'(ser_valid), 32'd0);
    check("abort_last", 32'(ser_last), 32'd0);
    check("abort_empty", 32'(fifo_empty), 32'd1);
    check("abort_ovf", 32'(ovf_cnt), 32'd0);
    R = 1'b1;
    tick(2);
    Q_in = WIDTH'($urandom); cap_en = 1'b1;
    tick(1);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
